debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
- Parametrised multi-channel switch debouncer; next generation of the fixed 16-input debouncer.
- Per channel: input synchroniser, shared tick prescaler, run-time hold threshold, saturating stability counter.
- Outputs per channel: debounced level, one-cycle rise/fall pulses, and sticky event flags.
- Sits between board pins (buttons, DIP switches) and the cog/IO register space.

Parameters:
- N_CH, 16, number of independent channels.
- CNT_W, 16, width of per-channel stability counter and of hold_ticks.
- SYNC_STAGES, 2, synchroniser flops per channel (legal 2..4).
- PRESCALE, 1000, clock cycles per debounce tick (legal >= 1; 1 = tick every cycle).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- switch  in  N_CH  raw asynchronous switch inputs.
- hold_ticks  in  CNT_W  ticks an input must stay stable before it is accepted; 0 is treated as 1; sampled every tick.
- event_clear  in  N_CH  write-1-to-clear mask for event_pending.
- switch_db  out  N_CH  debounced levels.
- rise  out  N_CH  one-cycle pulse when switch_db goes 0->1.
- fall  out  N_CH  one-cycle pulse when switch_db goes 1->0.
- event_pending  out  N_CH  sticky: set on any rise or fall.

Behaviour:
- Interface: one clock, named clock. Reset is asynchronous and active-high, named reset.
- Reset clears all state to 0: synchronisers, prescaler, counters, switch_db, rise, fall and event_pending.
- Synchroniser: SYNC_STAGES flop chain per channel. sync_q is the last stage.
- Prescaler:
  - Shared counter runs 0..PRESCALE-1.
  - tick is high for one cycle when the counter equals PRESCALE-1, then the counter wraps to 0.
  - When PRESCALE=1, tick is constant 1 after reset.
- Per channel, two states: STABLE (sync_q == switch_db) and PENDING (sync_q != switch_db).
  - In STABLE, cnt is held at 0.
  - In PENDING, on each tick, cnt increments with saturation at all-ones.
  - Accept when PENDING, tick is high, and cnt+1 >= max(hold_ticks,1). On the next clock edge:
    - switch_db <= sync_q;
    - cnt <= 0;
    - rise or fall pulses for exactly that one cycle.
  - Bounce: if sync_q returns to equal switch_db at any cycle (tick or not), cnt clears to 0 on the next edge. No output change.
- Latency: a clean input edge reaches switch_db after SYNC_STAGES cycles plus the wait for hold_ticks ticks (phase depends on the prescaler), plus 1 register cycle.
- rise and fall are never both high on the same channel in the same cycle. They are registered outputs.
- event_pending[i]:
  - set when rise[i] or fall[i] is high;
  - cleared by event_clear[i];
  - if set and clear occur in the same cycle, set wins.
- A change of hold_ticks mid-count takes effect at the next tick compare. Lowering it below the current cnt causes an accept on the next tick.
- Reset asserted mid-count: everything returns to 0 immediately (asynchronous). A switch held high at reset release produces a rise after the full hold time.
- Channels are fully independent. Only the prescaler is shared.

Decomposition:
- Package debounce_pkg:
  - localparam defaults (N_CH_DEF, CNT_W_DEF, PRESCALE_DEF);
  - function clog2-based prescaler width;
  - typedef enum {STABLE, PENDING} db_state_t.
- One sub-module: debounce_chan. It holds the synchroniser, counter, level and edge pulses for one channel, takes tick and hold_ticks as inputs, and is instantiated N_CH times in a generate loop.
- The prescaler and event_pending logic live in the top level.

Test Plan (N_CH=4, PRESCALE=4, SYNC_STAGES=2, hold_ticks=3 unless stated):
- Reset, then switch=4'b0000 for 100 cycles -> switch_db=0, no rise/fall, event_pending=0.
- switch[0] 0->1 held -> switch_db[0]=1 within 2+12+4 cycles of the edge. rise[0] is high for exactly 1 cycle, and event_pending[0]=1.
- switch[1] toggles every 5 cycles for 60 cycles, then stays 1 -> no pulses during the bouncing; exactly one rise[1] after it settles.
- Reach event_pending[2]=1, then assert event_clear[2] in the same cycle as a new fall[2] -> event_pending[2] stays 1. Pulsing event_clear[2] alone clears it.
- hold_ticks=0 with PRESCALE=1 -> accept after 2 sync cycles plus 1 cycle. Assert reset mid-PENDING -> outputs 0 immediately, and after release the full hold time is required again.
- All 4 channels change on the same cycle -> 4 independent rise pulses in the same cycle. Saturation check: CNT_W=2, hold_ticks=3 -> accept still occurs.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults, types and helpers for the switch debouncer bank
//
// Purpose: defaults for debounce_bank parameters, the per-channel state type
// and the prescaler width helper used by the top level.
package debounce_pkg;

  localparam int N_CH_DEF     = 16;
  localparam int CNT_W_DEF    = 16;
  localparam int PRESCALE_DEF = 1000;

  // STABLE: synchronised input matches the debounced level.
  // PENDING: they differ and the stability counter is running.
  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_t;

  // Width of a counter that runs 0..prescale-1. It never drops below one bit,
  // so the counter declaration stays legal for tiny prescale values.
  function automatic int prescale_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one debounce channel: synchroniser, stability counter, level and edges
//
// Purpose: debounces a single raw switch input against a shared tick.
// Ports:
//   clock, reset     system clock, asynchronous active-high reset
//   switch_i         raw asynchronous switch input
//   tick_i           shared debounce tick (one cycle wide)
//   hold_ticks_i     ticks of stability required before accepting (0 acts as 1)
//   switch_db_o      debounced level
//   rise_o, fall_o   registered one-cycle edge pulses of switch_db_o
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             switch_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] hold_ticks_i,
  output logic             switch_db_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
  logic                   sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  db_state_t              state;
  logic [CNT_W:0]         cnt_inc;
  logic [CNT_W:0]         hold_eff;
  logic                   accept;

  assign sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], switch_i};
  assign sync_q       = sync_chain_q[SYNC_STAGES-1];

  always_comb begin
    state    = (sync_q != db_q) ? PENDING : STABLE;
    // One extra bit so cnt+1 at all-ones still compares correctly.
    cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    hold_eff = (hold_ticks_i == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, hold_ticks_i};
    accept   = (state == PENDING) && tick_i && (cnt_inc >= hold_eff);

    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;

    if (state == STABLE) begin
      // Covers bounce-back too: any cycle of agreement restarts the count.
      cnt_d = '0;
    end else if (accept) begin
      db_d   = sync_q;
      cnt_d  = '0;
      rise_d = sync_q;
      fall_d = ~sync_q;
    end else if (tick_i && (cnt_q != '1)) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_chain_q <= '0;
      cnt_q        <= '0;
      db_q         <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
    end else begin
      sync_chain_q <= sync_chain_d;
      cnt_q        <= cnt_d;
      db_q         <= db_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
    end
  end

  assign switch_db_o = db_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel switch debouncer with shared tick prescaler and sticky events
//
// Purpose: N_CH independent debounce channels sharing one tick prescaler,
// plus write-1-to-clear sticky event flags.
// Ports:
//   clock, reset     system clock, asynchronous active-high reset
//   switch           raw asynchronous switch inputs
//   hold_ticks       stability time in ticks (0 acts as 1), sampled each tick
//   event_clear      write-1-to-clear mask for event_pending
//   switch_db        debounced levels
//   rise, fall       one-cycle pulses on debounced edges
//   event_pending    sticky flag per channel, set on any rise or fall
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE    = PRESCALE_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_CH-1:0]  switch,
  input  logic [CNT_W-1:0] hold_ticks,
  input  logic [N_CH-1:0]  event_clear,
  output logic [N_CH-1:0]  switch_db,
  output logic [N_CH-1:0]  rise,
  output logic [N_CH-1:0]  fall,
  output logic [N_CH-1:0]  event_pending
);

  localparam int PS_W = prescale_width(PRESCALE);

  logic            tick;
  logic [N_CH-1:0] ep_q, ep_d;

  generate
    if (PRESCALE == 1) begin : g_no_prescale
      assign tick = 1'b1;
    end else begin : g_prescale
      localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
      logic [PS_W-1:0] ps_q, ps_d;

      assign tick = (ps_q == PS_LAST);
      assign ps_d = tick ? '0 : ps_q + PS_W'(1);

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          ps_q <= '0;
        end else begin
          ps_q <= ps_d;
        end
      end
    end
  endgenerate

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
      debounce_chan #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
        .clock        (clock),
        .reset        (reset),
        .switch_i     (switch[i]),
        .tick_i       (tick),
        .hold_ticks_i (hold_ticks),
        .switch_db_o  (switch_db[i]),
        .rise_o       (rise[i]),
        .fall_o       (fall[i])
      );
    end
  endgenerate

  // Set terms are OR-ed after the clear so a same-cycle edge wins.
  assign ep_d = (ep_q & ~event_clear) | rise | fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ep_q <= '0;
    end else begin
      ep_q <= ep_d;
    end
  end

  assign event_pending = ep_q;

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - scoreboard bench for debounce_bank
module tb_debounce_bank;

  typedef struct {
    int         cyc;
    logic [3:0] r;
    logic [3:0] f;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_a, reset_b;
  logic [3:0] sw_a, clr_a, db_a, rise_a, fall_a, ep_a;
  logic [15:0] hold_a;
  logic [1:0] sw_b, clr_b, db_b, rise_b, fall_b, ep_b;
  logic [1:0] hold_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_a, cyc_b;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  always #5 clock = ~clock;

  debounce_bank #(.N_CH(4), .CNT_W(16), .SYNC_STAGES(2), .PRESCALE(4)) dut_a (
    .clock(clock), .reset(reset_a), .switch(sw_a), .hold_ticks(hold_a),
    .event_clear(clr_a), .switch_db(db_a), .rise(rise_a), .fall(fall_a),
    .event_pending(ep_a)
  );

  debounce_bank #(.N_CH(2), .CNT_W(2), .SYNC_STAGES(2), .PRESCALE(1)) dut_b (
    .clock(clock), .reset(reset_b), .switch(sw_b), .hold_ticks(hold_b),
    .event_clear(clr_b), .switch_db(db_b), .rise(rise_b), .fall(fall_b),
    .event_pending(ep_b)
  );

  // Edge count since reset release: after edge Ek the counter reads k.
  always @(posedge clock or posedge reset_a)
    if (reset_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;
  always @(posedge clock or posedge reset_b)
    if (reset_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_a(input int c, input logic [3:0] r, input logic [3:0] f);
    exp_t e;
    e.cyc = c; e.r = r; e.f = f;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int c, input logic [3:0] r, input logic [3:0] f);
    exp_t e;
    e.cyc = c; e.r = r; e.f = f;
    q_b.push_back(e);
  endtask

  task automatic wait_cyc(input bit sel_b, input int target);
    int n;
    n = 0;
    while (((sel_b ? cyc_b : cyc_a) < target) && (n < 500)) begin
      @(negedge clock);
      n++;
    end
    if ((sel_b ? cyc_b : cyc_a) < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_timeout: cycle %0d, required %0d", sel_b ? cyc_b : cyc_a, target);
    end
  endtask

  // Accept edge for an input first sampled at edge k: two sync edges, then
  // the first tick edge (multiple of p), then h-1 further ticks.
  function automatic int acc_edge(input int k, input int h, input int p);
    int t;
    t = k + 2;
    while ((t % p) != 0) t++;
    return t + ((h < 1) ? 0 : h - 1) * p;
  endfunction

  always @(negedge clock) begin
    if (!reset_a && ((rise_a | fall_a) != 4'b0)) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse_a: rise=%b fall=%b cycle=%0d, expected none", rise_a, fall_a, cyc_a);
      end else begin
        e_a = q_a.pop_front();
        chk("pulse_cycle_a", cyc_a, e_a.cyc);
        chk("rise_a", {28'b0, rise_a}, {28'b0, e_a.r});
        chk("fall_a", {28'b0, fall_a}, {28'b0, e_a.f});
      end
    end
  end

  always @(negedge clock) begin
    if (!reset_b && ((rise_b | fall_b) != 2'b0)) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse_b: rise=%b fall=%b cycle=%0d, expected none", rise_b, fall_b, cyc_b);
      end else begin
        e_b = q_b.pop_front();
        chk("pulse_cycle_b", cyc_b, e_b.cyc);
        chk("rise_b", {30'b0, rise_b}, {28'b0, e_b.r});
        chk("fall_b", {30'b0, fall_b}, {28'b0, e_b.f});
      end
    end
  end

  initial begin
    int c, acc;
    reset_a = 1'b1; reset_b = 1'b1;
    sw_a = '0; clr_a = '0; hold_a = 16'd3;
    sw_b = '0; clr_b = '0; hold_b = 2'd0;
    repeat (3) @(negedge clock);
    chk("reset_db_a", {28'b0, db_a}, 0);
    chk("reset_rise_fall_a", {28'b0, rise_a | fall_a}, 0);
    chk("reset_ep_a", {28'b0, ep_a}, 0);
    chk("reset_db_b", {30'b0, db_b}, 0);
    reset_a = 1'b0; reset_b = 1'b0;

    // Quiet inputs: nothing may move.
    repeat (100) @(negedge clock);
    chk("idle_db_a", {28'b0, db_a}, 0);
    chk("idle_ep_a", {28'b0, ep_a}, 0);

    // Clean rise on channel 0.
    c = cyc_a; sw_a[0] = 1'b1;
    push_a(acc_edge(c + 1, 3, 4), 4'b0001, 4'b0000);
    wait_cyc(0, c + 18);
    chk("ch0_db_within_bound", {31'b0, db_a[0]}, 1);
    chk("ch0_ep", {31'b0, ep_a[0]}, 1);
    chk("ch0_pulse_seen", q_a.size(), 0);

    // Channel 1 bounces every 5 cycles, then settles high.
    for (int i = 0; i < 12; i++) begin
      sw_a[1] = ~sw_a[1];
      repeat (5) @(negedge clock);
    end
    chk("ch1_db_during_bounce", {31'b0, db_a[1]}, 0);
    c = cyc_a; sw_a[1] = 1'b1;
    acc = acc_edge(c + 1, 3, 4);
    push_a(acc, 4'b0010, 4'b0000);
    wait_cyc(0, acc + 3);
    chk("ch1_db_settled", {31'b0, db_a[1]}, 1);
    chk("ch1_pulse_seen", q_a.size(), 0);

    // Channel 2: event flag, clear colliding with a new fall, then plain clear.
    c = cyc_a; sw_a[2] = 1'b1;
    acc = acc_edge(c + 1, 3, 4);
    push_a(acc, 4'b0100, 4'b0000);
    wait_cyc(0, acc + 2);
    chk("ch2_ep_set", {31'b0, ep_a[2]}, 1);
    c = cyc_a; sw_a[2] = 1'b0;
    acc = acc_edge(c + 1, 3, 4);
    push_a(acc, 4'b0000, 4'b0100);
    wait_cyc(0, acc);
    clr_a = 4'b0100;
    @(negedge clock);
    clr_a = 4'b0000;
    chk("ch2_set_wins_over_clear", {31'b0, ep_a[2]}, 1);
    clr_a = 4'b0100;
    @(negedge clock);
    clr_a = 4'b0000;
    chk("ch2_ep_cleared", {31'b0, ep_a[2]}, 0);
    chk("ch01_ep_kept", {30'b0, ep_a[1:0]}, 3);

    // Both high channels fall together, then all four rise together.
    c = cyc_a; sw_a = 4'b0000;
    acc = acc_edge(c + 1, 3, 4);
    push_a(acc, 4'b0000, 4'b0011);
    wait_cyc(0, acc + 2);
    c = cyc_a; sw_a = 4'b1111;
    acc = acc_edge(c + 1, 3, 4);
    push_a(acc, 4'b1111, 4'b0000);
    wait_cyc(0, acc + 2);
    chk("all_db_high", {28'b0, db_a}, 32'hF);
    chk("all_ep_set", {28'b0, ep_a}, 32'hF);

    // PRESCALE=1, hold 0: two sync cycles plus one register cycle.
    c = cyc_b; sw_b[1] = 1'b1;
    push_b(c + 3, 4'b0010, 4'b0000);
    wait_cyc(1, c + 5);
    chk("b_hold0_db", {30'b0, db_b}, 2);
    chk("b_hold0_ep", {30'b0, ep_b}, 2);

    // Reset in the middle of a pending count clears everything at once.
    hold_b = 2'd3;
    sw_b[0] = 1'b1;
    repeat (2) @(negedge clock);
    #2 reset_b = 1'b1;
    #1;
    chk("b_async_reset_db", {30'b0, db_b}, 0);
    chk("b_async_reset_ep", {30'b0, ep_b}, 0);
    chk("b_async_reset_pulses", {30'b0, rise_b | fall_b}, 0);
    @(negedge clock);
    reset_b = 1'b0;
    // Held-high inputs need the full 3-tick hold again (CNT_W=2, hold at max).
    push_b(5, 4'b0011, 4'b0000);
    wait_cyc(1, 4);
    chk("b_no_early_accept", {30'b0, db_b}, 0);
    wait_cyc(1, 7);
    chk("b_saturating_accept_db", {30'b0, db_b}, 3);

    // Lowering hold below the running count accepts on the next tick.
    c = cyc_b; sw_b[0] = 1'b0;
    push_b(c + 4, 4'b0000, 4'b0001);
    wait_cyc(1, c + 3);
    hold_b = 2'd1;
    wait_cyc(1, c + 6);
    chk("b_hold_lowered_db", {30'b0, db_b}, 2);

    repeat (20) @(negedge clock);
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
